data_memory: RTL and testbench

Block-addressed main data memory for the 8-bit processor: 64 blocks of 32 bits (256 bytes), serving whole-block read and write requests from the data cache's memory-side port. It sits directly downstream of the data cache, which drives `mem_read`/`mem_write`/`mem_address`/`mem_writedata` and stalls on `mem_busywait`. Each access takes a fixed, parameterised number of cycles, which models slow DRAM behind the cache.

---
 rtl/data_memory.sv | 90 +++++++++
 tb/tb_data_memory.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: 64 x 32-bit block memory behind the data cache.
// Each access is accepted in IDLE, held in BUSY for LATENCY cycles, and
// completes with a single DONE cycle in which busywait is low.
module data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  mem_address,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        op_write;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_array [0:63];

    logic req;
    assign req = mem_read | mem_write;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and combinational stall; requests only matter in IDLE
    always_comb begin
        state_next   = state;
        mem_busywait = 1'b0;
        case (state)
            IDLE: begin
                mem_busywait = req;
                if (req) state_next = BUSY;
            end
            BUSY: begin
                mem_busywait = 1'b1;
                if (cnt == 4'd0) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency countdown, and the commit at the end of BUSY.
    // Reset wins over a commit on the same edge, so an in-flight write is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= 4'd0;
            op_write     <= 1'b0;
            addr_q       <= 6'd0;
            wdata_q      <= 32'h0;
            mem_readdata <= 32'h0;
            for (int i = 0; i < 64; i++) mem_array[i] <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= mem_address;
                        wdata_q  <= mem_writedata;
                        // read wins when both are raised
                        op_write <= mem_write & ~mem_read;
                        cnt      <= 4'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (op_write) begin
                        mem_array[addr_q] <= wdata_q;
                    end else begin
                        mem_readdata <= mem_array[addr_q];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver pushes the expected outcome
// of each access, a monitor pops it when a busy window closes.
module tb_data_memory;

    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    data_memory #(.LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] data;   // readdata expected in DONE (held value for writes)
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [0:63];
    logic [31:0] last_rd;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          bcnt    = 0;

    // Monitor: a busy window ends when busywait falls; it must have lasted
    // LAT+1 cycles and the DONE cycle must show the expected block.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            bcnt = 0;
        end else if (mem_busywait) begin
            bcnt++;
        end else if (bcnt != 0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got busy window %0d with nothing pending", bcnt);
            end else begin
                e = sb.pop_front();
                if (bcnt != LAT + 1) begin
                    n_fail++;
                    $display("FAIL %s stall: got %0d busy cycles, want %0d", e.name, bcnt, LAT + 1);
                end else if (mem_readdata !== e.data) begin
                    n_fail++;
                    $display("FAIL %s data: got %h, want %h", e.name, mem_readdata, e.data);
                end
            end
            bcnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        last_rd = 32'h0;
    endtask

    // Push the architectural outcome of one request
    task automatic expect_acc(input string name, input logic rd, input logic wr,
                              input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        if (rd) last_rd = model[a];
        else if (wr) model[a] = d;
        e.name = name;
        e.data = last_rd;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!mem_busywait) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: busywait still %b, want 0", name, mem_busywait);
        end
    endtask

    // Raise a request in the cycle after the current one and hold it through DONE
    task automatic acc(input string name, input logic rd, input logic wr,
                       input logic [5:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
        expect_acc(name, rd, wr, a, d);
        wait_done(name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            mem_read = 0; mem_write = 0;
        end
    endtask

    initial begin
        reset = 1; mem_read = 0; mem_write = 0; mem_address = 0; mem_writedata = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("reset_readdata", mem_readdata, 32'h0);
        check("reset_busywait", {31'h0, mem_busywait}, 32'h0);

        acc("reset_read12", 1, 0, 6'd12, 32'h0);
        idle(1);

        acc("write37", 0, 1, 6'd37, 32'hDEADBEEF);
        idle(1);
        acc("read37", 1, 0, 6'd37, 32'h0);
        idle(1);

        acc("init9", 0, 1, 6'd9, 32'hA5A5A5A5);
        idle(1);
        acc("wb5", 0, 1, 6'd5, 32'h11223344);
        acc("fetch9", 1, 0, 6'd9, 32'h0);   // back-to-back, no idle gap
        idle(1);
        acc("read5", 1, 0, 6'd5, 32'h0);
        idle(1);

        // Inputs changed and dropped mid-access must not disturb the write to 20
        acc("init21", 0, 1, 6'd21, 32'h00000077);
        idle(1);
        @(posedge clock); #1;
        mem_write = 1; mem_address = 6'd20; mem_writedata = 32'hCAFEF00D;
        expect_acc("midwrite20", 0, 1, 6'd20, 32'hCAFEF00D);
        repeat (2) @(posedge clock);
        #1 mem_writedata = 32'h0; mem_address = 6'd21; mem_write = 0;
        wait_done("midwrite20");
        acc("read20", 1, 0, 6'd20, 32'h0);
        idle(1);
        acc("read21", 1, 0, 6'd21, 32'h0);
        idle(1);

        acc("init3", 0, 1, 6'd3, 32'h01020304);
        idle(1);
        acc("rdwr3", 1, 1, 6'd3, 32'hFFFFFFFF);
        idle(1);
        acc("reread3", 1, 0, 6'd3, 32'h0);
        idle(1);

        // Reset in the third BUSY cycle of a write to 40
        @(posedge clock); #1;
        mem_write = 1; mem_address = 6'd40; mem_writedata = 32'h12345678;
        sb.push_back('{name: "lost40", data: last_rd});
        repeat (3) @(posedge clock);
        #1 reset = 1; mem_write = 0;
        @(posedge clock); #1 reset = 0;
        model_reset();
        @(negedge clock);
        check("post_reset_busywait", {31'h0, mem_busywait}, 32'h0);
        check("post_reset_readdata", mem_readdata, 32'h0);
        acc("read40", 1, 0, 6'd40, 32'h0);
        idle(1);

        // Random mix, including both-high requests and back-to-back issue
        for (int k = 0; k < 60; k++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            acc("rand", op[0], op[1], 6'($urandom_range(0, 63)), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(3);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
